// File: rtl/mmio_rsp_arb_pkg.sv
// Shared types and sizing helpers for the MMIO response arbiter.
package mmio_rsp_arb_pkg;

   typedef logic [8:0]  t_ccip_tid;
   typedef logic [63:0] t_ccip_mmioData;

   typedef struct packed {
      t_ccip_tid      tid;
      t_ccip_mmioData data;
   } t_mmio_rsp;

   // Width of an index that selects one of n sources (never narrower than 1 bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mmio_rsp_fifo.sv
// Small per-source response FIFO. Push and pop may coincide in any state;
// a push into a full FIFO is accepted only when the same cycle pops it.
module mmio_rsp_fifo
   import mmio_rsp_arb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  t_mmio_rsp push_data,
   input  logic      pop,
   output t_mmio_rsp head,
   output logic      empty,
   output logic      full
);

   localparam int PW = $clog2(FIFO_DEPTH);

   t_mmio_rsp     mem_r [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [PW:0]   count_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign empty     = (count_r == {(PW+1){1'b0}});
   assign full      = (count_r == (PW+1)'(FIFO_DEPTH));
   assign push_ok_s = push & (~full | pop);
   assign pop_ok_s  = pop & ~empty;
   assign head      = mem_r[rd_ptr_r];

   // Storage write; entries need no reset because occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (push_ok_s && !reset) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; occupancy tracks push/pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {(PW+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         count_r <= count_r + (PW+1)'(push_ok_s) - (PW+1)'(pop_ok_s);
      end
   end

endmodule

// File: rtl/mmio_rsp_arb.sv
// Merges MMIO read responses from several CSR sources onto one c2Tx channel.
// Each source feeds its own FIFO; a round-robin scheduler drains one per cycle.
module mmio_rsp_arb
   import mmio_rsp_arb_pkg::*;
#(
   parameter int NUM_SRCS   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_SRCS-1:0]           src_rsp_valid,
   input  logic [NUM_SRCS-1:0][8:0]      src_rsp_tid,
   input  logic [NUM_SRCS-1:0][63:0]     src_rsp_data,
   output logic                          c2Tx_mmioRdValid,
   output logic [8:0]                    c2Tx_tid,
   output logic [63:0]                   c2Tx_data,
   output logic [NUM_SRCS-1:0]           rsp_overflow,
   output logic [63:0]                   ctr_conflicts
);

   localparam int IW = idx_width(NUM_SRCS);

   t_mmio_rsp             head_s [NUM_SRCS];
   logic [NUM_SRCS-1:0]   empty_s;
   logic [NUM_SRCS-1:0]   full_s;
   logic [NUM_SRCS-1:0]   pop_s;
   logic [NUM_SRCS-1:0]   drop_s;
   logic                  grant_valid_s;
   logic [IW-1:0]         grant_idx_s;
   logic [IW-1:0]         rr_next_s;
   logic                  multi_s;
   int                    cand_s;

   logic [IW-1:0]         rr_ptr_r;
   logic                  rsp_valid_r;
   t_ccip_tid             tid_r;
   t_ccip_mmioData        data_r;
   logic [NUM_SRCS-1:0]   overflow_r;
   logic [63:0]           conflicts_r;

   for (genvar i = 0; i < NUM_SRCS; i++) begin : g_fifo
      t_mmio_rsp push_data_s;
      assign push_data_s = '{tid: src_rsp_tid[i], data: src_rsp_data[i]};

      mmio_rsp_fifo #(
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk       (clk),
         .reset     (reset),
         .push      (src_rsp_valid[i]),
         .push_data (push_data_s),
         .pop       (pop_s[i]),
         .head      (head_s[i]),
         .empty     (empty_s[i]),
         .full      (full_s[i])
      );
   end

   // Rotating-priority grant: first non-empty FIFO at or after rr_ptr.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_idx_s   = {IW{1'b0}};
      cand_s        = 0;
      for (int k = 0; k < NUM_SRCS; k++) begin
         cand_s = (int'(rr_ptr_r) + k) % NUM_SRCS;
         if (!grant_valid_s && !empty_s[cand_s]) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = IW'(cand_s);
         end else begin
            grant_valid_s = grant_valid_s;
         end
      end
   end

   // Pop decode, drop detection, next pointer and contention detect.
   always_comb begin
      pop_s  = {NUM_SRCS{1'b0}};
      drop_s = {NUM_SRCS{1'b0}};
      for (int i = 0; i < NUM_SRCS; i++) begin
         pop_s[i]  = grant_valid_s && (grant_idx_s == IW'(i));
         drop_s[i] = src_rsp_valid[i] & full_s[i] & ~pop_s[i];
      end
      if (grant_idx_s == IW'(NUM_SRCS - 1)) begin
         rr_next_s = {IW{1'b0}};
      end else begin
         rr_next_s = grant_idx_s + IW'(1);
      end
      multi_s = ($countones(~empty_s) >= 32'd2);
   end

   // Output register, round-robin pointer, sticky drop flags and conflict counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_r    <= {IW{1'b0}};
         rsp_valid_r <= 1'b0;
         tid_r       <= 9'd0;
         data_r      <= 64'd0;
         overflow_r  <= {NUM_SRCS{1'b0}};
         conflicts_r <= 64'd0;
      end else begin
         if (grant_valid_s) begin
            rsp_valid_r <= 1'b1;
            tid_r       <= head_s[grant_idx_s].tid;
            data_r      <= head_s[grant_idx_s].data;
            rr_ptr_r    <= rr_next_s;
         end else begin
            rsp_valid_r <= 1'b0;
         end
         overflow_r <= overflow_r | drop_s;
         if (multi_s) begin
            conflicts_r <= conflicts_r + 64'd1;
         end
      end
   end

   assign c2Tx_mmioRdValid = rsp_valid_r;
   assign c2Tx_tid         = tid_r;
   assign c2Tx_data        = data_r;
   assign rsp_overflow     = overflow_r;
   assign ctr_conflicts    = conflicts_r;

endmodule

// File: tb/tb_mmio_rsp_arb.sv
// Directed self-checking bench for mmio_rsp_arb (NUM_SRCS=2, FIFO_DEPTH=4).
module tb_mmio_rsp_arb;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [1:0]       src_rsp_valid = 2'b00;
   logic [1:0][8:0]  src_rsp_tid = '0;
   logic [1:0][63:0] src_rsp_data = '0;
   logic             c2Tx_mmioRdValid;
   logic [8:0]       c2Tx_tid;
   logic [63:0]      c2Tx_data;
   logic [1:0]       rsp_overflow;
   logic [63:0]      ctr_conflicts;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      int          cyc;
      logic [8:0]  tid;
      logic [63:0] data;
   } ev_t;
   ev_t out_q[$];

   mmio_rsp_arb #(.NUM_SRCS(2), .FIFO_DEPTH(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .src_rsp_valid    (src_rsp_valid),
      .src_rsp_tid      (src_rsp_tid),
      .src_rsp_data     (src_rsp_data),
      .c2Tx_mmioRdValid (c2Tx_mmioRdValid),
      .c2Tx_tid         (c2Tx_tid),
      .c2Tx_data        (c2Tx_data),
      .rsp_overflow     (rsp_overflow),
      .ctr_conflicts    (ctr_conflicts)
   );

   always #5 clk = ~clk;

   // cycle index; cycle N spans posedge N .. posedge N+1
   always @(posedge clk) cyc <= cyc + 1;

   // record every emitted response, sampled mid-cycle
   always @(negedge clk) begin
      if (c2Tx_mmioRdValid) out_q.push_back('{cyc: cyc, tid: c2Tx_tid, data: c2Tx_data});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      src_rsp_valid = 2'b00;
      src_rsp_tid   = '0;
      src_rsp_data  = '0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      out_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      src_rsp_valid = 2'b11;
      src_rsp_tid[0] = 9'h1AA;
      src_rsp_tid[1] = 9'h1BB;
      tick();
      tick();
      idle_inputs();
      reset = 1'b0;
      out_q.delete();
      checks++;
      if (c2Tx_mmioRdValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", c2Tx_mmioRdValid); end
      checks++;
      if (c2Tx_tid !== 9'd0 || c2Tx_data !== 64'd0) begin failures++; $display("FAIL reset_tid_data got=%h/%h exp=0/0", c2Tx_tid, c2Tx_data); end
      checks++;
      if (rsp_overflow !== 2'b00 || ctr_conflicts !== 64'd0) begin failures++; $display("FAIL reset_flags got=%b/%0d exp=00/0", rsp_overflow, ctr_conflicts); end
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (out_q.size() != 0) begin failures++; $display("FAIL reset_push_ignored got=%0d emissions exp=0", out_q.size()); end
   endtask

   task automatic test_single();
      int n;
      apply_reset();
      n = cyc;
      src_rsp_valid = 2'b01;
      src_rsp_tid[0] = 9'h005;
      src_rsp_data[0] = 64'h0000_0000_DEAD_BEEF;
      tick();
      idle_inputs();
      checks++;
      if (c2Tx_mmioRdValid !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", c2Tx_mmioRdValid); end
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (out_q.size() != 1) begin
         failures++; $display("FAIL single_count got=%0d exp=1", out_q.size());
      end else begin
         if (out_q[0].cyc != n + 2 || out_q[0].tid !== 9'h005 || out_q[0].data !== 64'h0000_0000_DEAD_BEEF) begin
            failures++;
            $display("FAIL single_rsp got=cyc%0d/%h/%h exp=cyc%0d/005/deadbeef", out_q[0].cyc, out_q[0].tid, out_q[0].data, n + 2);
         end
      end
      checks++;
      if (c2Tx_tid !== 9'h005 || c2Tx_data !== 64'h0000_0000_DEAD_BEEF) begin failures++; $display("FAIL single_hold got=%h/%h exp=005/deadbeef", c2Tx_tid, c2Tx_data); end
      checks++;
      if (ctr_conflicts !== 64'd0) begin failures++; $display("FAIL single_ctr got=%0d exp=0", ctr_conflicts); end
   endtask

   task automatic test_collision();
      int n;
      apply_reset();
      n = cyc;
      src_rsp_valid = 2'b11;
      src_rsp_tid[0] = 9'h011;
      src_rsp_tid[1] = 9'h022;
      src_rsp_data[0] = 64'h1111;
      src_rsp_data[1] = 64'h2222;
      tick();
      idle_inputs();
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (out_q.size() != 2) begin
         failures++; $display("FAIL collision_count got=%0d exp=2", out_q.size());
      end else begin
         checks++;
         if (out_q[0].tid !== 9'h011 || out_q[0].cyc != n + 2 || out_q[0].data !== 64'h1111) begin
            failures++; $display("FAIL collision_first got=%h@%0d exp=011@%0d", out_q[0].tid, out_q[0].cyc, n + 2);
         end
         checks++;
         if (out_q[1].tid !== 9'h022 || out_q[1].cyc != n + 3 || out_q[1].data !== 64'h2222) begin
            failures++; $display("FAIL collision_second got=%h@%0d exp=022@%0d", out_q[1].tid, out_q[1].cyc, n + 3);
         end
      end
      checks++;
      if (ctr_conflicts !== 64'd1) begin failures++; $display("FAIL collision_ctr got=%0d exp=1", ctr_conflicts); end
   endtask

   task automatic test_fairness();
      int n;
      int exp0[$];
      int exp1[$];
      logic [8:0] etid;
      logic [63:0] edata;
      apply_reset();
      n = cyc;
      for (int k = 0; k < 20; k++) begin
         src_rsp_valid = 2'b11;
         src_rsp_tid[0] = 9'(k);
         src_rsp_tid[1] = 9'h100 | 9'(k);
         src_rsp_data[0] = {32'hA0A0_0000, 32'(k)};
         src_rsp_data[1] = {32'hB0B0_0000, 32'(k)};
         tick();
         // hand-derived: FIFOs saturate at cycle 7; then the non-granted source drops each cycle
         if (k <= 7 || (k % 2) == 1) exp0.push_back(k);
         if (k <= 6 || (k % 2) == 0) exp1.push_back(k);
      end
      idle_inputs();
      for (int i = 0; i < 12; i++) tick();
      checks++;
      if (out_q.size() != 27) begin failures++; $display("FAIL fair_count got=%0d exp=27", out_q.size()); end
      for (int j = 0; j < out_q.size() && j < 27; j++) begin
         if (j % 2 == 0) begin
            etid = 9'(exp0[j/2]);
            edata = {32'hA0A0_0000, 32'(exp0[j/2])};
         end else begin
            etid = 9'h100 | 9'(exp1[j/2]);
            edata = {32'hB0B0_0000, 32'(exp1[j/2])};
         end
         checks++;
         if (out_q[j].tid !== etid || out_q[j].data !== edata || out_q[j].cyc != n + 2 + j) begin
            failures++;
            $display("FAIL fair_rsp%0d got=%h/%h@%0d exp=%h/%h@%0d", j, out_q[j].tid, out_q[j].data, out_q[j].cyc, etid, edata, n + 2 + j);
         end
      end
      checks++;
      if (rsp_overflow !== 2'b11) begin failures++; $display("FAIL fair_overflow got=%b exp=11", rsp_overflow); end
      checks++;
      if (ctr_conflicts !== 64'd26) begin failures++; $display("FAIL fair_ctr got=%0d exp=26", ctr_conflicts); end
   endtask

   task automatic test_overflow_boundary();
      int n;
      logic [8:0] etid;
      apply_reset();
      n = cyc;
      for (int k = 0; k < 7; k++) begin
         src_rsp_valid = 2'b11;
         src_rsp_tid[0] = 9'(k);
         src_rsp_tid[1] = 9'h100 | 9'(k);
         tick();
      end
      checks++;
      if (rsp_overflow !== 2'b00) begin failures++; $display("FAIL ovf_full_no_drop got=%b exp=00", rsp_overflow); end
      // FIFO 0 full but popped this cycle: push accepted
      src_rsp_valid = 2'b01;
      src_rsp_tid[0] = 9'd7;
      tick();
      checks++;
      if (rsp_overflow !== 2'b00) begin failures++; $display("FAIL ovf_push_pop got=%b exp=00", rsp_overflow); end
      // FIFO 0 full and not popped: dropped
      src_rsp_tid[0] = 9'd8;
      tick();
      idle_inputs();
      checks++;
      if (rsp_overflow !== 2'b01) begin failures++; $display("FAIL ovf_drop got=%b exp=01", rsp_overflow); end
      for (int i = 0; i < 12; i++) tick();
      checks++;
      if (out_q.size() != 15) begin failures++; $display("FAIL ovf_count got=%0d exp=15", out_q.size()); end
      for (int j = 0; j < out_q.size() && j < 15; j++) begin
         etid = (j % 2 == 0) ? 9'(j/2) : (9'h100 | 9'(j/2));
         checks++;
         if (out_q[j].tid !== etid || out_q[j].cyc != n + 2 + j) begin
            failures++; $display("FAIL ovf_rsp%0d got=%h@%0d exp=%h@%0d", j, out_q[j].tid, out_q[j].cyc, etid, n + 2 + j);
         end
      end
      checks++;
      if (rsp_overflow !== 2'b01 || ctr_conflicts !== 64'd14) begin
         failures++; $display("FAIL ovf_final got=%b/%0d exp=01/14", rsp_overflow, ctr_conflicts);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      apply_reset();
      src_rsp_valid = 2'b11;
      src_rsp_tid[0] = 9'h031;
      src_rsp_tid[1] = 9'h032;
      tick();
      src_rsp_valid = 2'b01;
      src_rsp_tid[0] = 9'h033;
      tick();
      idle_inputs();
      checks++;
      if (ctr_conflicts !== 64'd1 || c2Tx_mmioRdValid !== 1'b1) begin
         failures++; $display("FAIL mid_pre got=%0d/%b exp=1/1", ctr_conflicts, c2Tx_mmioRdValid);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      out_q.delete();
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (out_q.size() != 0) begin failures++; $display("FAIL mid_flush got=%0d emissions exp=0", out_q.size()); end
      checks++;
      if (rsp_overflow !== 2'b00 || ctr_conflicts !== 64'd0) begin
         failures++; $display("FAIL mid_flags got=%b/%0d exp=00/0", rsp_overflow, ctr_conflicts);
      end
      n = cyc;
      src_rsp_valid = 2'b11;
      src_rsp_tid[0] = 9'h051;
      src_rsp_tid[1] = 9'h052;
      tick();
      idle_inputs();
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (out_q.size() != 2) begin
         failures++; $display("FAIL mid_after_count got=%0d exp=2", out_q.size());
      end else if (out_q[0].tid !== 9'h051 || out_q[0].cyc != n + 2 || out_q[1].tid !== 9'h052) begin
         failures++;
         $display("FAIL mid_after_order got=%h@%0d,%h exp=051@%0d,052", out_q[0].tid, out_q[0].cyc, out_q[1].tid, n + 2);
      end
   endtask

   task automatic test_idle();
      logic [63:0] ctr_snap;
      ctr_snap = ctr_conflicts;
      out_q.delete();
      idle_inputs();
      for (int i = 0; i < 100; i++) tick();
      checks++;
      if (out_q.size() != 0 || c2Tx_mmioRdValid !== 1'b0) begin
         failures++; $display("FAIL idle_valid got=%0d emissions exp=0", out_q.size());
      end
      checks++;
      if (ctr_conflicts !== ctr_snap) begin failures++; $display("FAIL idle_ctr got=%0d exp=%0d", ctr_conflicts, ctr_snap); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_collision();
      test_fairness();
      test_overflow_boundary();
      test_reset_mid();
      test_idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mmio_rsp_arb.md
# mmio_rsp_arb

Arbiter that merges MMIO read responses from several independent CSR sources onto the single CCI-P c2Tx channel toward the FIU. It sits between the CSR manager, the AFU's own CSR logic and any other CSR-owning shims, and the FIU-side c2Tx register. Each source gets a small response FIFO, and a round-robin scheduler drains the FIFOs one response per cycle. This removes the loss that occurs when two sources return a response in the same cycle.

## Interface
Parameters:
- NUM_SRCS, 2: number of response sources, at least 2.
- FIFO_DEPTH, 4: entries per source FIFO; power of 2, at least 2.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high.
- src_rsp_valid  in  NUM_SRCS  one-cycle pulse per response from source i.
- src_rsp_tid  in  NUM_SRCS x 9  t_ccip_tid of each response.
- src_rsp_data  in  NUM_SRCS x 64  t_ccip_mmioData of each response.
- c2Tx_mmioRdValid  out  1  registered response valid toward the FIU.
- c2Tx_tid  out  9  registered tid.
- c2Tx_data  out  64  registered data.
- rsp_overflow  out  NUM_SRCS  sticky per-source drop flag.
- ctr_conflicts  out  64  count of cycles with two or more FIFOs non-empty.

## Operation
- Sources cannot be backpressured, because CCI-P MMIO responses carry no ready signal. A response with src_rsp_valid[i]=1 is pushed into FIFO i at the end of that cycle.
- Push into full FIFO i:
  - If FIFO i is also popped in the same cycle, the push is accepted and occupancy stays at FIFO_DEPTH.
  - Otherwise the response is dropped, rsp_overflow[i] is set, and existing entries are untouched.
- Scheduler, each cycle:
  - Scan non-empty FIFOs starting at rr_ptr, wrapping modulo NUM_SRCS.
  - Pop the first non-empty FIFO found and load its head into the output register with c2Tx_mmioRdValid=1.
  - Set rr_ptr to (granted index + 1) mod NUM_SRCS.
  - If all FIFOs are empty, drive c2Tx_mmioRdValid=0 and leave rr_ptr unchanged.
- At most one response is emitted per cycle. Per-source ordering is preserved. Ordering across sources is round-robin only.
- c2Tx_tid and c2Tx_data are don't-care while c2Tx_mmioRdValid=0. The implementation holds their last values.
- ctr_conflicts increments by 1 in every cycle in which at least two FIFOs are non-empty before that cycle's pop. It wraps from 2^64-1 to 0.
- rsp_overflow bits are cleared only by reset.
- Reset values and effects:
  - c2Tx_mmioRdValid=0.
  - c2Tx_tid=0 and c2Tx_data=0.
  - rsp_overflow=0 and ctr_conflicts=0.
  - rr_ptr=0.
  - All FIFOs empty.
  - src_rsp_valid asserted while reset=1 is ignored (no push).
- Reset asserted mid-operation discards all queued responses in the same clock edge. No response is emitted in the cycle after reset.

## Timing
- Uncontended latency is 2 cycles:
  - Pulse in cycle N writes FIFO i at the end of cycle N.
  - FIFO i is granted in cycle N+1.
  - c2Tx_mmioRdValid=1 is visible in cycle N+2.
- No combinational path from src_* inputs to c2Tx_* outputs.
- With K responses arriving simultaneously from K distinct sources, they emerge in K consecutive cycles starting at N+2, in round-robin order from rr_ptr.
- A single source streaming one response per cycle, with no other traffic, sustains one output per cycle. Its FIFO never exceeds occupancy 1.
- rsp_overflow[i] becomes visible the cycle after the dropped push.
- ctr_conflicts updates with 1-cycle register latency.

## Structure
- Shared package mmio_rsp_arb_pkg holds:
  - t_mmio_rsp struct {t_ccip_tid tid; t_ccip_mmioData data;}.
  - Index width function/constant derived from NUM_SRCS.
- Sub-module mmio_rsp_fifo, instantiated NUM_SRCS times:
  - Parameter FIFO_DEPTH.
  - Ports: clk, reset, push, push_data, pop, head, empty, full.
  - Occupancy counter of width $clog2(FIFO_DEPTH)+1.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop is legal in every state. When empty, push and pop cannot coincide because pop requires non-empty.
- Top level holds the rr_ptr register, the priority-rotate grant logic, the output register, the sticky flags and the counter.

## Test plan
- Single response: NUM_SRCS=2, source 0 pulses tid=0x05, data=0xDEAD_BEEF in cycle 10 -> c2Tx_mmioRdValid=1, tid=0x05, data=0xDEADBEEF in cycle 12 only. ctr_conflicts stays 0.
- Collision: sources 0 and 1 pulse tid 0x11 and 0x22 in the same cycle after reset -> 0x11 emitted at N+2, 0x22 at N+3. ctr_conflicts=1.
- Round-robin fairness: both sources pulse every cycle for 20 cycles, FIFO_DEPTH=4 -> outputs alternate 0,1,0,1. Source FIFOs fill, and rsp_overflow becomes 2'b11 once pushes exceed drain rate. Emitted tids per source stay in order.
- Overflow at boundary: stall drain by keeping source 1 busy, push 5 responses into source 0 with depth 4 -> fifth dropped, rsp_overflow[0]=1. The first four are emitted intact.
- Reset mid-operation: 3 responses queued, reset high for 1 cycle -> no c2Tx_mmioRdValid afterward. Flags and counter are 0. The next new response emits 2 cycles after arrival, granted from rr_ptr=0.
- Idle: no pulses for 100 cycles -> c2Tx_mmioRdValid held 0 and ctr_conflicts unchanged.
